ctr_record_sequencer: RTL and testbench

Sequences control transfer records from the per-commit-port emitter into the single-write-port CTR record storage. Filters records by cftype and freeze state, compacts up to NrCommitPorts records per cycle into a small in-order queue, and drains one record per cycle through a valid/ready write port. It owns the storage write pointer and runs the storage clear sweep. Sits between the CTR emitter and the CTR record storage/CSR block inside the CTR unit.

---
 rtl/ctr_record_sequencer_pkg.sv | 59 +++++
 rtl/ctr_record_queue.sv | 58 +++++
 rtl/ctr_record_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ctr_record_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_record_sequencer_pkg.sv
// rtl/ctr_record_sequencer_pkg.sv - CTR record types, sequencer state encoding and core config for the CTR record sequencer
package ctr_record_sequencer_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

    typedef enum logic [3:0] {
        CTR_NONE    = 4'd0,
        CTR_EXC     = 4'd1,
        CTR_INT     = 4'd2,
        CTR_TRET    = 4'd3,
        CTR_NTBR    = 4'd4,
        CTR_TKBR    = 4'd5,
        CTR_INDCALL = 4'd8,
        CTR_DIRCALL = 4'd9,
        CTR_INDJMP  = 4'd10,
        CTR_DIRJMP  = 4'd11,
        CTR_CORSWAP = 4'd12,
        CTR_RET     = 4'd13,
        CTR_INDLJMP = 4'd14,
        CTR_DIRLJMP = 4'd15
    } ctr_type_t;

    typedef struct packed {
        logic [62:0] pc;
        logic        v;
    } ctrsource_rv_t;

    typedef struct packed {
        logic [62:0] pc;
        logic        misp;
    } ctrtarget_rv_t;

    typedef struct packed {
        logic [15:0] cc;
        logic        ccv;
        ctr_type_t   cftype;
    } ctrdata_rv_t;

    typedef struct packed {
        ctrsource_rv_t source;
        ctrtarget_rv_t target;
        ctrdata_rv_t   data;
    } ctr_record_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } ctr_seq_state_e;

    // Circular pointer advance for queues whose depth need not be a power of two.
    function automatic int unsigned wrap_add(int unsigned ptr, int unsigned inc, int unsigned depth);
        return (ptr + inc) % depth;
    endfunction

endpackage

// File: rtl/ctr_record_queue.sv
// rtl/ctr_record_queue.sv - multi-push, single-pop circular record queue (registered, no fall-through)
module ctr_record_queue
    import ctr_record_sequencer_pkg::*;
#(
    parameter int unsigned NrPorts = 2,
    parameter int unsigned Depth   = 4,
    localparam int unsigned CntW   = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic [CntW-1:0] push_cnt_i,
    input  ctr_record_t     push_data_i [NrPorts],
    input  logic            pop_i,
    output ctr_record_t     head_o,
    output logic            empty_o,
    output logic [CntW-1:0] free_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    ctr_record_t     mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] cnt_q;

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    // A slot vacated by this cycle's pop is already usable by this cycle's push.
    assign free_o  = CntW'(Depth) - cnt_q + CntW'(pop_i);

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrPorts; k++) begin
            if (CntW'(k) < push_cnt_i) begin
                mem_q[PtrW'(wrap_add(32'(wr_ptr_q), k, Depth))] <= push_data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= PtrW'(wrap_add(32'(wr_ptr_q), 32'(push_cnt_i), Depth));
            if (pop_i) begin
                rd_ptr_q <= PtrW'(wrap_add(32'(rd_ptr_q), 1, Depth));
            end
            cnt_q <= cnt_q + push_cnt_i - CntW'(pop_i);
        end
    end

endmodule

// File: rtl/ctr_record_sequencer.sv
// rtl/ctr_record_sequencer.sv - filters, queues and drains CTR records into storage; optional drop counter under CTR_DROP_COUNTER_EN
module ctr_record_sequencer
    import ctr_record_sequencer_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
    parameter int unsigned QueueDepth    = 4,
    parameter int unsigned CtrDepth      = 16,
    localparam int unsigned NrCommitPorts = CVA6Cfg.NrCommitPorts,
    localparam int unsigned IdxW          = $clog2(CtrDepth)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  ctrsource_rv_t   source_i [NrCommitPorts],
    input  ctrtarget_rv_t   target_i [NrCommitPorts],
    input  ctrdata_rv_t     data_i   [NrCommitPorts],
    input  logic [15:0]     cftype_en_i,
    input  logic            freeze_i,
    input  logic            clear_i,
    output logic            wr_valid_o,
    input  logic            wr_ready_i,
    output logic [IdxW-1:0] wr_idx_o,
    output ctrsource_rv_t   wr_source_o,
    output ctrtarget_rv_t   wr_target_o,
    output ctrdata_rv_t     wr_data_o,
    output logic [IdxW-1:0] wrptr_o,
    output logic            overflow_o,
    output logic            busy_o
`ifdef CTR_DROP_COUNTER_EN
    ,
    output logic [7:0]      drop_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    ctr_seq_state_e     state_q, state_d;
    logic [IdxW-1:0]    wrptr_q, sweep_q;
    logic               overflow_q;
    logic [NrCommitPorts-1:0] accept;
    ctr_record_t        push_vec [NrCommitPorts];
    logic [CntW-1:0]    n_push, n_drop, q_free;
    ctr_record_t        q_head;
    logic               q_empty;
    logic               hs, pop;

    assign hs  = wr_valid_o & wr_ready_i;
    assign pop = hs & (state_q == RUN);

    always_comb begin
        accept = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            accept[i] = source_i[i].v & cftype_en_i[data_i[i].cftype] & ~freeze_i
                      & ~clear_i & (state_q == RUN);
        end
    end

    // Compact accepted ports in ascending order; anything beyond the free count is dropped.
    always_comb begin
        push_vec = '{default: '0};
        n_push   = '0;
        n_drop   = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            if (accept[i]) begin
                if (n_push < q_free) begin
                    for (int j = 0; j < NrCommitPorts; j++) begin
                        if (n_push == CntW'(j)) begin
                            push_vec[j] = '{source: source_i[i], target: target_i[i], data: data_i[i]};
                        end
                    end
                    n_push = n_push + CntW'(1);
                end else begin
                    n_drop = n_drop + CntW'(1);
                end
            end
        end
    end

    ctr_record_queue #(
        .NrPorts (NrCommitPorts),
        .Depth   (QueueDepth)
    ) i_queue (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (clear_i),
        .push_cnt_i  (n_push),
        .push_data_i (push_vec),
        .pop_i       (pop),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .free_o      (q_free)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (clear_i) state_d = CLEAR;
            end
            CLEAR: begin
                if (!clear_i && hs && (sweep_q == IdxW'(CtrDepth - 1))) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_valid_o  = 1'b0;
        wr_idx_o    = wrptr_q;
        wr_source_o = '0;
        wr_target_o = '0;
        wr_data_o   = '0;
        busy_o      = 1'b0;
        case (state_q)
            RUN: begin
                wr_valid_o = ~q_empty;
                if (!q_empty) begin
                    wr_source_o = q_head.source;
                    wr_target_o = q_head.target;
                    wr_data_o   = q_head.data;
                end
            end
            CLEAR: begin
                wr_valid_o = 1'b1;
                wr_idx_o   = sweep_q;
                busy_o     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrptr_q    <= '0;
            sweep_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (clear_i) begin
                wrptr_q <= '0;
            end else if (pop) begin
                wrptr_q <= wrptr_q + IdxW'(1);
            end
            if (clear_i) begin
                sweep_q <= '0;
            end else if ((state_q == CLEAR) && hs) begin
                sweep_q <= sweep_q + IdxW'(1);
            end
            if (clear_i) begin
                overflow_q <= 1'b0;
            end else if (n_drop != '0) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign wrptr_o    = wrptr_q;
    assign overflow_o = overflow_q;

`ifdef CTR_DROP_COUNTER_EN
    logic [7:0] drop_cnt_q;
    logic [8:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 9'(n_drop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            drop_cnt_q <= '0;
        end else if (drop_sum[8]) begin
            drop_cnt_q <= 8'hFF;
        end else begin
            drop_cnt_q <= drop_sum[7:0];
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ctr_record_sequencer.sv
// tb/tb_ctr_record_sequencer.sv - directed self-checking bench for ctr_record_sequencer
module tb_ctr_record_sequencer;
    import ctr_record_sequencer_pkg::*;

    localparam int NP = cva6_cfg_empty.NrCommitPorts;

    logic          clk = 1'b0;
    logic          rstn_i;
    ctrsource_rv_t source_i [NP];
    ctrtarget_rv_t target_i [NP];
    ctrdata_rv_t   data_i   [NP];
    logic [15:0]   cftype_en_i;
    logic          freeze_i, clear_i, wr_ready_i;
    logic          wr_valid_o;
    logic [3:0]    wr_idx_o, wrptr_o;
    ctrsource_rv_t wr_source_o;
    ctrtarget_rv_t wr_target_o;
    ctrdata_rv_t   wr_data_o;
    logic          overflow_o, busy_o;
`ifdef CTR_DROP_COUNTER_EN
    logic [7:0]    drop_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    ctr_record_sequencer dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .source_i    (source_i),
        .target_i    (target_i),
        .data_i      (data_i),
        .cftype_en_i (cftype_en_i),
        .freeze_i    (freeze_i),
        .clear_i     (clear_i),
        .wr_valid_o  (wr_valid_o),
        .wr_ready_i  (wr_ready_i),
        .wr_idx_o    (wr_idx_o),
        .wr_source_o (wr_source_o),
        .wr_target_o (wr_target_o),
        .wr_data_o   (wr_data_o),
        .wrptr_o     (wrptr_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
`ifdef CTR_DROP_COUNTER_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) begin
            source_i[p] = '0;
            target_i[p] = '0;
            data_i[p]   = '0;
        end
    endtask

    task automatic put(input int p, input logic [62:0] pc, input ctr_type_t t);
        source_i[p].pc     = pc;
        source_i[p].v      = 1'b1;
        target_i[p].pc     = pc + 63'h1000;
        target_i[p].misp   = 1'b0;
        data_i[p].cc       = 16'h0;
        data_i[p].ccv      = 1'b0;
        data_i[p].cftype   = t;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        idle();
        cftype_en_i = 16'hFFFF;
        freeze_i = 1'b0;
        clear_i = 1'b0;
        wr_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", wr_valid_o); end
        checks++; if (wr_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", wr_idx_o); end
        checks++; if (wrptr_o !== 4'd0) begin errors++; $display("FAIL reset_wrptr: got %0d want 0", wrptr_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        checks++; if (wr_source_o !== '0) begin errors++; $display("FAIL reset_payload: got %0h want 0", wr_source_o); end
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_single();
        put(0, 63'h100, CTR_TKBR);
        checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL single_not_fallthrough: got %0b want 0", wr_valid_o); end
        tick();
        idle();
        checks++; if (wr_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", wr_valid_o); end
        checks++; if (wr_idx_o !== 4'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", wr_idx_o); end
        checks++; if (wr_source_o.pc !== 63'h100) begin errors++; $display("FAIL single_pc: got %0h want 100", wr_source_o.pc); end
        tick();
        checks++; if (wrptr_o !== 4'd1) begin errors++; $display("FAIL single_wrptr: got %0d want 1", wrptr_o); end
        checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b want 0", wr_valid_o); end
    endtask

    task automatic test_filter();
        cftype_en_i = 16'hFFFF & ~(16'h1 << CTR_DIRCALL);
        put(0, 63'h200, CTR_DIRCALL);
        put(1, 63'h201, CTR_TKBR);
        tick();
        idle();
        checks++; if (wr_source_o.pc !== 63'h201) begin errors++; $display("FAIL filter_pc: got %0h want 201", wr_source_o.pc); end
        checks++; if (wr_idx_o !== 4'd1) begin errors++; $display("FAIL filter_idx: got %0d want 1", wr_idx_o); end
        tick();
        checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL filter_only_one: got %0b want 0", wr_valid_o); end
        cftype_en_i = 16'hFFFF;
        freeze_i = 1'b1;
        put(0, 63'h202, CTR_TKBR);
        put(1, 63'h203, CTR_RET);
        tick();
        idle();
        freeze_i = 1'b0;
        checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL freeze_valid: got %0b want 0", wr_valid_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL freeze_overflow: got %0b want 0", overflow_o); end
        checks++; if (wrptr_o !== 4'd2) begin errors++; $display("FAIL freeze_wrptr: got %0d want 2", wrptr_o); end
    endtask

    task automatic test_overflow();
        logic [62:0] exp_pc [4];
        exp_pc[0] = 63'h301; exp_pc[1] = 63'h302; exp_pc[2] = 63'h303; exp_pc[3] = 63'h306;
        wr_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            put(0, 63'h300 + 63'(2 * b), CTR_TKBR);
            put(1, 63'h301 + 63'(2 * b), CTR_NTBR);
            tick();
        end
        idle();
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow_o); end
        checks++; if (wr_source_o.pc !== 63'h300) begin errors++; $display("FAIL ovf_head: got %0h want 300", wr_source_o.pc); end
        checks++; if (wr_idx_o !== 4'd2) begin errors++; $display("FAIL ovf_idx: got %0d want 2", wr_idx_o); end
`ifdef CTR_DROP_COUNTER_EN
        checks++; if (drop_cnt_o !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt_o); end
`endif
        // full queue, pop and push in the same cycle: the popped slot takes the new record
        wr_ready_i = 1'b1;
        put(0, 63'h306, CTR_TKBR);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            checks++; if (wr_valid_o !== 1'b1 || wr_source_o.pc !== exp_pc[k] || wr_idx_o !== 4'(3 + k))
                begin errors++; $display("FAIL ovf_drain%0d: got v=%0b pc=%0h idx=%0d want pc=%0h idx=%0d", k, wr_valid_o, wr_source_o.pc, wr_idx_o, exp_pc[k], 3 + k); end
            tick();
        end
        checks++; if (wr_valid_o !== 1'b0 || wrptr_o !== 4'd7) begin errors++; $display("FAIL ovf_end: got v=%0b wrptr=%0d want v=0 wrptr=7", wr_valid_o, wrptr_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow_o); end
`ifdef CTR_DROP_COUNTER_EN
        checks++; if (drop_cnt_o !== 8'd2) begin errors++; $display("FAIL ovf_drop_hold: got %0d want 2", drop_cnt_o); end
`endif
    endtask

    task automatic test_wrap();
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        checks++; if (overflow_o !== 1'b0 || wrptr_o !== 4'd0) begin errors++; $display("FAIL wrap_reset: got ovf=%0b wrptr=%0d want 0 0", overflow_o, wrptr_o); end
        for (int k = 0; k < 18; k++) begin
            idle();
            if (k < 17) put(0, 63'h400 + 63'(k), CTR_DIRJMP);
            if (k >= 1) begin
                checks++; if (wr_valid_o !== 1'b1 || wr_source_o.pc !== 63'h400 + 63'(k - 1) || wr_idx_o !== 4'((k - 1) % 16))
                    begin errors++; $display("FAIL wrap_rec%0d: got v=%0b pc=%0h idx=%0d want pc=%0h idx=%0d", k - 1, wr_valid_o, wr_source_o.pc, wr_idx_o, 'h400 + k - 1, (k - 1) % 16); end
            end
            tick();
        end
        idle();
        checks++; if (wr_valid_o !== 1'b0 || wrptr_o !== 4'd1) begin errors++; $display("FAIL wrap_end: got v=%0b wrptr=%0d want v=0 wrptr=1", wr_valid_o, wrptr_o); end
    endtask

    task automatic test_clear();
        wr_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            put(0, 63'h600 + 63'(2 * b), CTR_TKBR);
            put(1, 63'h601 + 63'(2 * b), CTR_TKBR);
            tick();
        end
        idle();
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %0b want 1", overflow_o); end
        wr_ready_i = 1'b1;
        clear_i = 1'b1;
        put(0, 63'h606, CTR_TKBR);
        tick();
        clear_i = 1'b0;
        idle();
        checks++; if (busy_o !== 1'b1 || wrptr_o !== 4'd0) begin errors++; $display("FAIL clr_start: got busy=%0b wrptr=%0d want 1 0", busy_o, wrptr_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b want 0", overflow_o); end
`ifdef CTR_DROP_COUNTER_EN
        checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt_o); end
`endif
        for (int s = 0; s < 16; s++) begin
            checks++; if (wr_valid_o !== 1'b1 || wr_idx_o !== 4'(s) || wr_source_o !== '0 || busy_o !== 1'b1)
                begin errors++; $display("FAIL clr_sweep%0d: got v=%0b idx=%0d src=%0h busy=%0b want 1 %0d 0 1", s, wr_valid_o, wr_idx_o, wr_source_o, busy_o, s); end
            if (s == 3) put(0, 63'h607, CTR_TKBR);
            tick();
            idle();
        end
        checks++; if (busy_o !== 1'b0 || wr_valid_o !== 1'b0 || wrptr_o !== 4'd0) begin errors++; $display("FAIL clr_end: got busy=%0b v=%0b wrptr=%0d want 0 0 0", busy_o, wr_valid_o, wrptr_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_end_ovf: got %0b want 0", overflow_o); end
    endtask

    task automatic test_clear_restart();
        int n;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int s = 0; s < 7; s++) tick();
        checks++; if (wr_idx_o !== 4'd7) begin errors++; $display("FAIL rst_sweep_at7: got %0d want 7", wr_idx_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checks++; if (wr_idx_o !== 4'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL rst_sweep_restart: got idx=%0d busy=%0b want 0 1", wr_idx_o, busy_o); end
        n = 0;
        while (busy_o === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL rst_sweep_len: got %0d want 16", n); end
    endtask

    task automatic test_back_to_back();
        wr_ready_i = 1'b0;
        put(0, 63'h500, CTR_RET);
        put(1, 63'h501, CTR_RET);
        tick();
        idle();
        put(0, 63'h502, CTR_RET);
        tick();
        idle();
        for (int k = 0; k < 6; k++) begin
            wr_ready_i = k[0];
            checks++; if (wr_valid_o !== 1'b1 || wr_source_o.pc !== 63'h500 + 63'(k / 2) || wr_idx_o !== 4'(k / 2))
                begin errors++; $display("FAIL bp_cycle%0d: got v=%0b pc=%0h idx=%0d want pc=%0h idx=%0d", k, wr_valid_o, wr_source_o.pc, wr_idx_o, 'h500 + k / 2, k / 2); end
            tick();
        end
        checks++; if (wr_valid_o !== 1'b0 || wrptr_o !== 4'd3) begin errors++; $display("FAIL bp_end: got v=%0b wrptr=%0d want 0 3", wr_valid_o, wrptr_o); end
    endtask

    task automatic test_reset_midsweep();
        wr_ready_i = 1'b1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        tick();
        #2;
        rstn_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || wr_valid_o !== 1'b0 || wr_idx_o !== 4'd0) begin errors++; $display("FAIL async_reset: got busy=%0b v=%0b idx=%0d want 0 0 0", busy_o, wr_valid_o, wr_idx_o); end
        tick();
        rstn_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_overflow();
        test_wrap();
        test_clear();
        test_clear_restart();
        test_back_to_back();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
